// File: rtl/keypad_encoder.sv
// keypad_encoder: synchronises and debounces four raw door-keypad buttons and
// emits one single-cycle one-hot btn pulse per accepted press. Chords raise
// multi_err instead of a pulse; a key held too long raises stuck.
module keypad_encoder #(
    parameter int DEB_CYCLES   = 4,
    parameter int STUCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rs,
    input  logic [4:1] btn_raw,
    output logic [4:1] btn,
    output logic [2:0] key_code,
    output logic       busy,
    output logic       multi_err,
    output logic       stuck
);

    localparam int CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [4:1]        sync_p0;
    logic [4:1]        btn_s;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [4:1]        cand, cand_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [4:1]        btn_nxt;
    logic [2:0]        key_nxt;
    logic              multi_nxt;
    logic              stuck_nxt;

    // True when exactly one key is present in the pattern.
    function automatic logic is_one_hot(input logic [4:1] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Binary key number (1..4) of a one-hot pattern.
    function automatic logic [2:0] key_index(input logic [4:1] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i <= 4; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Hold counter increment that stops at its ceiling instead of wrapping.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + HOLD_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            sync_p0 <= '0;
            btn_s   <= '0;
        end else begin
            sync_p0 <= btn_raw;
            btn_s   <= sync_p0;
        end
    end

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= '0;
            hold_cnt  <= '0;
            btn       <= '0;
            key_code  <= '0;
            busy      <= 1'b0;
            multi_err <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            hold_cnt  <= hold_nxt;
            btn       <= btn_nxt;
            key_code  <= key_nxt;
            busy      <= (state_nxt != ST_IDLE);
            multi_err <= multi_nxt;
            stuck     <= stuck_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low so they last one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        hold_nxt  = hold_cnt;
        btn_nxt   = '0;
        key_nxt   = key_code;
        multi_nxt = 1'b0;
        stuck_nxt = stuck;
        case (state)
            ST_IDLE: begin
                if (btn_s != '0) begin
                    cand_nxt  = btn_s;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (btn_s == '0) begin
                    state_nxt = ST_IDLE;
                end else if (btn_s != cand) begin
                    // a different pattern restarts the stability count
                    cand_nxt = btn_s;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else begin
                    if (is_one_hot(cand)) begin
                        btn_nxt = cand;
                        key_nxt = key_index(cand);
                    end else begin
                        multi_nxt = 1'b1;
                    end
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (btn_s == '0) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = ST_RELEASE;
                end else begin
                    // pattern changes while held are ignored; only duration matters
                    hold_nxt  = hold_sat_inc(hold_cnt);
                    stuck_nxt = (hold_nxt == HOLD_MAX);
                end
            end
            ST_RELEASE: begin
                if (btn_s != '0) begin
                    // release glitch: resume holding with the hold time intact
                    state_nxt = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    hold_nxt  = '0;
                    stuck_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder: directed scenarios plus random presses,
// checked cycle by cycle against a run-length reference model via a scoreboard.
module tb_keypad_encoder;

    localparam int DEB   = 4;
    localparam int STUCK = 16;

    logic       clk;
    logic       rs;
    logic [4:1] btn_raw;
    logic [4:1] btn;
    logic [2:0] key_code;
    logic       busy;
    logic       multi_err;
    logic       stuck;

    keypad_encoder #(
        .DEB_CYCLES  (DEB),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .clk      (clk),
        .rs       (rs),
        .btn_raw  (btn_raw),
        .btn      (btn),
        .key_code (key_code),
        .busy     (busy),
        .multi_err(multi_err),
        .stuck    (stuck)
    );

    typedef struct packed {
        logic [4:1] btn;
        logic [2:0] key;
        logic       busy;
        logic       merr;
        logic       stuck;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int btn_pulses  = 0;
    int merr_pulses = 0;

    // reference model state: two sample delays, run length of identical
    // synchronised samples, whether a press is currently accepted, hold time
    logic [4:1] m_sy1, m_sy2, m_last;
    int         m_run, m_hold;
    bit         m_pressed;
    logic [2:0] m_key;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_sy1 = '0; m_sy2 = '0; m_last = '0;
        m_run = 0; m_hold = 0; m_pressed = 0; m_key = '0;
    endtask

    // Expected outputs after the coming clock edge with btn_raw = raw.
    // A press is accepted once the synchronised pattern has been the same
    // nonzero value for DEB consecutive samples; it is released once zero
    // has been seen for DEB consecutive samples.
    task automatic model_edge(input logic [4:1] raw);
        logic [4:1] samp;
        exp_t e;
        samp  = m_sy2;
        m_sy2 = m_sy1;
        m_sy1 = raw;
        e = '0;
        if (samp == m_last) begin
            if (m_run < 100000) m_run++;
        end else begin
            m_run = 1;
        end
        if (m_pressed) begin
            if (samp != '0 && m_last != '0) begin
                if (m_hold < STUCK) m_hold++;
            end else if (samp == '0 && m_run == DEB) begin
                m_pressed = 0;
                m_hold    = 0;
            end
        end else if (samp != '0 && m_run == DEB) begin
            m_pressed = 1;
            if ($countones(samp) == 1) begin
                e.btn = samp;
                for (int i = 1; i <= 4; i++) if (samp[i]) m_key = 3'(i);
            end else begin
                e.merr = 1'b1;
            end
        end
        m_last  = samp;
        e.key   = m_key;
        e.busy  = m_pressed || (samp != '0);
        e.stuck = (m_hold >= STUCK);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [4:1] raw);
        @(negedge clk);
        rs      = 1'b1;
        btn_raw = raw;
        model_edge(raw);
    endtask

    task automatic hold(input logic [4:1] raw, input int n);
        for (int i = 0; i < n; i++) step(raw);
    endtask

    // Assert reset between edges, check outputs clear at once, hold 3 edges.
    task automatic do_reset(input logic [4:1] raw);
        @(negedge clk);
        btn_raw = raw;
        rs      = 1'b0;
        #1;
        vectors++;
        if ({btn, key_code, busy, multi_err, stuck} != '0) begin
            miscompares++;
            $display("FAIL reset_async: got btn=%b key=%0d busy=%b merr=%b stuck=%b, want all 0",
                     btn, key_code, busy, multi_err, stuck);
        end
        model_reset();
        exp_q.push_back('0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back('0);
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d pulses, want %0d", name, got, want);
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (btn != '0) btn_pulses++;
            if (multi_err) merr_pulses++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (btn !== e.btn || key_code !== e.key || busy !== e.busy ||
                    multi_err !== e.merr || stuck !== e.stuck) begin
                    miscompares++;
                    $display("FAIL cycle@%0t: got btn=%b key=%0d busy=%b merr=%b stuck=%b, want btn=%b key=%0d busy=%b merr=%b stuck=%b",
                             $time, btn, key_code, busy, multi_err, stuck,
                             e.btn, e.key, e.busy, e.merr, e.stuck);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int b0, m0;
        logic [4:1] pat;
        rs      = 1'b1;
        btn_raw = '0;
        model_reset();
        do_reset('0);
        hold('0, 3);

        // clean press
        b0 = btn_pulses;
        hold(4'b0001, 20);
        hold('0, 12);
        check_count("clean_press", btn_pulses - b0, 1);

        // bounce then stable
        b0 = btn_pulses;
        for (int i = 0; i < 3; i++) begin
            hold(4'b0100, 2);
            hold('0, 2);
        end
        hold(4'b0100, 12);
        hold('0, 12);
        check_count("bounce", btn_pulses - b0, 1);

        // chord
        b0 = btn_pulses; m0 = merr_pulses;
        hold(4'b0101, 12);
        hold('0, 12);
        check_count("chord_btn", btn_pulses - b0, 0);
        check_count("chord_merr", merr_pulses - m0, 1);

        // pattern switch during debounce
        b0 = btn_pulses;
        hold(4'b0001, 2);
        hold(4'b1000, 12);
        hold('0, 12);
        check_count("switch", btn_pulses - b0, 1);

        // release glitch then stuck
        b0 = btn_pulses;
        hold(4'b0010, 10);
        hold('0, 2);
        hold(4'b0010, 30);
        hold('0, 12);
        check_count("glitch_stuck", btn_pulses - b0, 1);

        // reset mid-debounce, then a fresh debounce
        b0 = btn_pulses;
        hold(4'b0001, 3);
        do_reset(4'b0001);
        hold(4'b0001, 12);
        hold('0, 12);
        check_count("reset_mid", btn_pulses - b0, 1);

        // random presses with bounce, chords, glitches and occasional resets
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 5) == 0) pat = 4'($urandom_range(1, 15));
            else                           pat = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    hold(pat, $urandom_range(1, 3));
                    hold('0, $urandom_range(1, 3));
                end
            end
            hold(pat, $urandom_range(1, 25));
            if ($urandom_range(0, 3) == 0) begin
                hold('0, $urandom_range(1, 3));
                hold(4'($urandom_range(1, 15)), $urandom_range(1, 6));
            end
            if ($urandom_range(0, 19) == 0) do_reset(pat);
            hold('0, $urandom_range(1, 8));
        end
        hold('0, 12);

        // let the monitor drain the scoreboard (bounded)
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
